// File: rtl/mips_pkg.sv
// Shared MIPS32 core definitions: widths, instruction field positions and fetch-stage types.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  // sll $0,$0,0 doubles as the pipeline bubble
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } if_id_payload_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface if_fetch_stage_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/if_fetch_stage_pipe_reg.sv
// IF/ID pipeline register with load and flush; Rs/Rt are captured alongside the instruction.
module if_id_pipe_reg
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_flush,
  input  if_id_payload_t   i_data,
  output logic [XLEN-1:0]  o_instr,
  output logic [XLEN-1:0]  o_pc_plus4,
  output logic             o_valid,
  output logic [REG_W-1:0] o_rs,
  output logic [REG_W-1:0] o_rt
);

  // Flush wins over load; a bubble keeps the previous pc_plus4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_instr    <= NOP_INSTR;
      o_pc_plus4 <= '0;
      o_valid    <= 1'b0;
      o_rs       <= '0;
      o_rt       <= '0;
    end else if (i_flush) begin
      o_instr    <= NOP_INSTR;
      o_valid    <= 1'b0;
      o_rs       <= NOP_INSTR[RS_MSB:RS_LSB];
      o_rt       <= NOP_INSTR[RT_MSB:RT_LSB];
    end else if (i_load) begin
      o_instr    <= i_data.instr;
      o_pc_plus4 <= i_data.pc_plus4;
      o_valid    <= 1'b1;
      o_rs       <= i_data.instr[RS_MSB:RS_LSB];
      o_rt       <= i_data.instr[RT_MSB:RT_LSB];
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack sequencing, skid buffer and wrong-path squash.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      PC_Enable,
  input  logic                      IF_ID_Pipeline_Enable,
  input  logic                      branch_taken,
  input  logic [XLEN-1:0]           branch_target,
  if_fetch_stage_if.master          imem,
  output logic [XLEN-1:0]           if_id_instr,
  output logic [XLEN-1:0]           if_id_pc_plus4,
  output logic                      if_id_valid,
  output logic [REG_W-1:0]          IF_ID_Reg_Rs,
  output logic [REG_W-1:0]          IF_ID_Reg_Rt
);

  fetch_state_e    r_state, w_next_state;
  logic [XLEN-1:0] r_pc, w_next_pc;
  logic [XLEN-1:0] r_skid, w_next_skid;
  logic            r_req, w_next_req;
  logic [XLEN-1:0] r_addr, w_next_addr;

  logic            w_consume, w_redirect, w_ack;
  logic            w_load, w_flush;
  logic [XLEN-1:0] w_target, w_pc_plus4;
  if_id_payload_t  w_payload;

  assign w_consume  = PC_Enable & IF_ID_Pipeline_Enable;
  assign w_redirect = branch_taken & IF_ID_Pipeline_Enable;
  assign w_ack      = imem.imem_ack & r_req;
  assign w_target   = word_align(branch_target);
  assign w_pc_plus4 = r_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_skid  <= '0;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_skid  <= w_next_skid;
      r_req   <= w_next_req;
      r_addr  <= w_next_addr;
    end
  end

  // Next state, pc, skid and IF/ID control; redirect outranks every other rule.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_skid  = r_skid;
    w_load       = 1'b0;
    w_flush      = 1'b0;

    case (r_state)
      IDLE: w_next_state = FETCH;

      FETCH: begin
        if (w_redirect) begin
          w_flush      = 1'b1;
          w_next_pc    = w_target;
          w_next_state = w_ack ? FETCH : DROP;
        end else if (w_ack) begin
          if (w_consume) begin
            w_load    = 1'b1;
            w_next_pc = w_pc_plus4;
          end else begin
            w_next_skid  = imem.imem_rdata;
            w_next_state = HOLD;
          end
        end else if (IF_ID_Pipeline_Enable) begin
          w_flush = 1'b1;
        end
      end

      HOLD: begin
        if (w_redirect) begin
          w_flush      = 1'b1;
          w_next_pc    = w_target;
          w_next_state = FETCH;
        end else if (w_consume) begin
          w_load       = 1'b1;
          w_next_pc    = w_pc_plus4;
          w_next_state = FETCH;
        end
      end

      DROP: begin
        if (w_redirect) begin
          w_flush   = 1'b1;
          w_next_pc = w_target;
        end
        if (w_ack) begin
          w_next_state = FETCH;
        end
      end

      default: w_next_state = IDLE;
    endcase
  end

  // Request lines are registered; DROP keeps presenting the abandoned address until acked.
  always_comb begin
    w_next_req  = (w_next_state == FETCH) || (w_next_state == DROP);
    w_next_addr = (w_next_state == DROP) ? r_addr : w_next_pc;
  end

  always_comb begin
    w_payload.instr    = (r_state == HOLD) ? r_skid : imem.imem_rdata;
    w_payload.pc_plus4 = w_pc_plus4;
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;

  if_id_pipe_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_data     (w_payload),
    .o_instr    (if_id_instr),
    .o_pc_plus4 (if_id_pc_plus4),
    .o_valid    (if_id_valid),
    .o_rs       (IF_ID_Reg_Rs),
    .o_rt       (IF_ID_Reg_Rt)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised self-checking bench for if_fetch_stage against a flag-based fetch model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_en, ie, bt, ack;
  logic [31:0] tgt;
  logic [31:0] instr, pc4;
  logic        valid;
  logic [4:0]  rs, rt;

  int checks = 0;
  int errors = 0;

  if_fetch_stage_if imem_bus ();

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B9) ^ 32'h0123_4567;
  endfunction

  assign imem_bus.imem_ack   = ack;
  assign imem_bus.imem_rdata = word_at(imem_bus.imem_addr);

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .PC_Enable             (pc_en),
    .IF_ID_Pipeline_Enable (ie),
    .branch_taken          (bt),
    .branch_target         (tgt),
    .imem                  (imem_bus),
    .if_id_instr           (instr),
    .if_id_pc_plus4        (pc4),
    .if_id_valid           (valid),
    .IF_ID_Reg_Rs          (rs),
    .IF_ID_Reg_Rt          (rt)
  );

  always #5 clk = ~clk;

  // Reference model: pending word, discard flag and the instruction stream seen by decode.
  bit          m_run, m_skid_full, m_discard, m_valid;
  logic [31:0] m_pc, m_skid, m_drop_addr, m_instr, m_pc4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_req();
    return m_run && !m_skid_full;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_discard ? m_drop_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_run = 0; m_skid_full = 0; m_discard = 0; m_valid = 0;
    m_pc = RESET_PC; m_skid = 0; m_drop_addr = 0; m_instr = 0; m_pc4 = 0;
  endtask

  task automatic deliver(input logic [31:0] w);
    m_instr = w;
    m_pc4   = m_pc + 32'd4;
    m_valid = 1;
    m_pc    = m_pc + 32'd4;
  endtask

  task automatic bubble();
    m_instr = 32'h0;
    m_valid = 0;
  endtask

  task automatic model_step();
    bit          req_now, acked, consume, redirect;
    logic [31:0] a_now;
    req_now  = exp_req();
    a_now    = exp_addr();
    acked    = ack && req_now;
    consume  = pc_en && ie;
    redirect = bt && ie;
    if (!m_run) begin
      m_run = 1;
    end else if (m_discard) begin
      if (redirect) m_pc = tgt & ~32'h3;
      if (acked) m_discard = 0;
    end else if (redirect) begin
      bubble();
      if (req_now && !acked) begin
        m_discard   = 1;
        m_drop_addr = m_pc;
      end
      m_pc        = tgt & ~32'h3;
      m_skid_full = 0;
    end else if (m_skid_full) begin
      if (consume) begin
        deliver(m_skid);
        m_skid_full = 0;
      end
    end else if (acked) begin
      if (consume) deliver(word_at(a_now));
      else begin
        m_skid      = word_at(a_now);
        m_skid_full = 1;
      end
    end else if (ie) begin
      bubble();
    end
  endtask

  task automatic compare_all();
    chk("req", 32'(imem_bus.imem_req), 32'(exp_req()));
    if (exp_req()) chk("addr", imem_bus.imem_addr, exp_addr());
    chk("instr", instr, m_instr);
    chk("pc_plus4", pc4, m_pc4);
    chk("valid", 32'(valid), 32'(m_valid));
    chk("rs", 32'(rs), 32'(m_instr[25:21]));
    chk("rt", 32'(rt), 32'(m_instr[20:16]));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_bus.imem_req), 32'h0);
    chk({tag, "_addr"}, imem_bus.imem_addr, RESET_PC);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_pc4"}, pc4, 32'h0);
    chk({tag, "_valid"}, 32'(valid), 32'h0);
    chk({tag, "_rs"}, 32'(rs), 32'h0);
    chk({tag, "_rt"}, 32'(rt), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    pc_en = 1; ie = 1; bt = 0; tgt = 0; ack = 0; rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1;

    // Zero-wait memory: first request in cycle 1, first instruction in cycle 2
    ack = 1;
    step();
    chk("first_req", 32'(imem_bus.imem_req), 32'h1);
    chk("first_addr", imem_bus.imem_addr, 32'h0);
    step();
    chk("first_instr", instr, 32'h2008_0005);
    chk("first_pc4", pc4, 32'h4);
    chk("first_rs", 32'(rs), 32'h0);
    chk("first_rt", 32'(rt), 32'h8);
    chk("first_valid", 32'(valid), 32'h1);
    repeat (4) step();

    // Slow memory acking every third cycle
    for (int i = 0; i < 12; i++) begin
      ack = (i % 3 == 2);
      step();
    end

    // Stall during an acked fetch: word parks in the skid buffer
    ack = 1;
    step();
    pc_en = 0; ie = 0;
    step();
    chk("hold_req", 32'(imem_bus.imem_req), 32'h0);
    repeat (2) step();
    pc_en = 1; ie = 1;
    step();
    step();

    // Redirect while the request is outstanding: late word dropped
    ack = 0; bt = 1; tgt = 32'h0000_0103;
    step();
    bt = 0; ack = 1;
    step();
    chk("drop_addr", imem_bus.imem_addr, 32'h0000_0100);
    chk("drop_valid", 32'(valid), 32'h0);
    step();
    chk("target_instr", instr, word_at(32'h0000_0100));

    // Branch during an IF/ID stall is ignored
    ie = 0; bt = 1; tgt = 32'h0000_4000;
    step();
    bt = 0; ie = 1;
    repeat (2) step();

    // PC wrap-around
    bt = 1; tgt = 32'hFFFF_FFFC; ack = 1;
    step();
    bt = 0;
    step();
    chk("wrap_addr", imem_bus.imem_addr, 32'h0);
    chk("wrap_pc4", pc4, 32'h0);

    // Asynchronous reset in the middle of an outstanding request
    ack = 0;
    step();
    #2 rst_n = 0;
    #1 chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      pc_en = ($urandom_range(7) != 0);
      ie    = ($urandom_range(7) != 0);
      bt    = ($urandom_range(9) == 0);
      tgt   = $urandom;
      ack   = $urandom_range(1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS32 core. It owns the PC, talks to instruction memory over a req/ack handshake, and presents the fetched instruction plus its Rs/Rt fields to decode and to the hazard/forwarding unit. It honours that unit's PC and IF/ID enables and squashes wrong-path fetches on a taken ID-stage branch.

## Interface
- RESET_PC, default 32'h0000_0000: byte address fetched first after reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- PC_Enable  in  1  hazard-unit PC enable; 0 = load-use stall.
- IF_ID_Pipeline_Enable  in  1  hazard-unit IF/ID enable; 0 = hold IF/ID.
- branch_taken  in  1  taken branch/jump resolved in ID this cycle.
- branch_target  in  32  redirect address; bits [1:0] ignored and forced to 0.
- imem_req  out  1  fetch request; level, held until acked.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1.
- imem_ack  in  1  memory accepts and returns data this cycle; ignored when imem_req=0.
- imem_rdata  in  32  instruction word, valid when imem_req & imem_ack.
- if_id_instr  out  32  IF/ID instruction; 32'h0 (sll $0 NOP) when invalid.
- if_id_pc_plus4  out  32  address of the IF/ID instruction + 4.
- if_id_valid  out  1  IF/ID holds a real instruction.
- IF_ID_Reg_Rs  out  5  if_id_instr[25:21].
- IF_ID_Reg_Rt  out  5  if_id_instr[20:16].

## Operation
- consume = PC_Enable & IF_ID_Pipeline_Enable. redirect = branch_taken & IF_ID_Pipeline_Enable. branch_taken during a stall is ignored.
- States: IDLE (reset only), FETCH (imem_req=1, addr=pc), HOLD (word captured in skid buffer, imem_req=0), DROP (imem_req=1, addr=old pc, returning word discarded).
- IDLE: -> FETCH on the first edge after reset release.
- FETCH with ack and consume: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4; stay FETCH.
- FETCH with ack and no consume: skid <= rdata; IF/ID held; -> HOLD.
- FETCH, no ack, IF_ID_Pipeline_Enable=1: IF/ID <= bubble (instr=0, valid=0). With enable=0: IF/ID held.
- HOLD with consume: IF/ID <= {skid, pc+4, 1}; pc <= pc+4; -> FETCH. Otherwise hold.
- redirect has priority over every rule above. IF/ID <= bubble. pc <= {branch_target[31:2],2'b00}. Any skid word is discarded. There is no delay slot.
  - From FETCH with ack, or from HOLD: -> FETCH.
  - From FETCH without ack: -> DROP. An issued request is never withdrawn.
- DROP: on ack, discard the word and -> FETCH. Another redirect while in DROP updates pc only.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Reset values: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, IF_ID_Reg_Rs=0, IF_ID_Reg_Rt=0, skid=0. Reset asserted mid-request aborts immediately. No handshake completion is required.

## Timing
- imem_req and imem_addr are decoded from registered state and pc only. There are no combinational paths from imem_ack or rdata to them.
- Zero-wait memory (ack same cycle as req): one instruction per cycle. Word acked in cycle n is visible on IF/ID in cycle n+1.
- First request is in cycle 1 after reset release. The first instruction appears in IF/ID in cycle 2 with zero-wait memory.
- Taken branch in cycle n with zero-wait memory: target is requested in cycle n+1 and appears in IF/ID in n+2. That is exactly one bubble.
- Stall: IF/ID and pc are held for as many cycles as the enables are low. No fetched word is lost or duplicated.
- IF_ID_Reg_Rs and IF_ID_Reg_Rt are registered together with if_id_instr. They are never decoded from imem_rdata.

## Structure
- Shared package mips_pkg holds:
  - NOP_INSTR = 32'h0000_0000;
  - the fetch-state enum {IDLE, FETCH, HOLD, DROP};
  - field positions RS_MSB=25, RS_LSB=21, RT_MSB=20, RT_LSB=16.
- One natural sub-module: if_id_pipe_reg. It is the enable/flush register for {instr, pc_plus4, valid, rs, rt}. The FSM, pc and skid buffer stay in if_fetch_stage.

## Test plan
- Reset, zero-wait memory returning 32'h2008_0005 at 0: imem_addr=0 in cycle 1. IF/ID in cycle 2 has instr 32'h2008_0005, pc_plus4 4, Rs 0, Rt 8, valid 1.
- Memory acking every third cycle: IF/ID shows valid instructions separated by two bubbles (instr 0, valid 0). pc advances by 4 per ack only.
- Enables low for 3 cycles during an acked fetch: state HOLD, imem_req=0, IF/ID unchanged. On release the skid word enters IF/ID once. The next request uses pc+4.
- branch_taken with target 32'h0000_0103 while the request is unacked: DROP. The late word never reaches IF/ID. The next request address is 32'h0000_0100.
- branch_taken while IF_ID_Pipeline_Enable=0: ignored. pc and IF/ID are unchanged.
- pc at 32'hFFFF_FFFC acked and consumed: next imem_addr = 0. Assert rst_n low mid-request: all outputs return to reset values asynchronously.
